cnt_seq_arb: RTL and testbench
==============================

CNT_SEQ_ARB -- requirements
Module: cnt_seq_arb

Interface
REQ-001 Parameter TERM_UP, default 4'hF, terminal count for up jobs.
REQ-002 Parameter TERM_DN, default 4'h0, terminal count for down jobs.
REQ-003 CLK  input  1  single clock; all state changes on posedge CLK.
REQ-004 RST  input  1  asynchronous, active-high reset.
REQ-005 REQ  input  2  level request per requester; bit i = requester i.
REQ-006 DIR  input  2  per-requester count direction; 0 = up, 1 = down.
REQ-007 LDV0  input  4  preload value for requester 0.
REQ-008 LDV1  input  4  preload value for requester 1.
REQ-009 CNT_Q  input  4  current value of the shared loadable up/down counter.
REQ-010 CNT_D  output  4  preload value driven to the counter.
REQ-011 CNT_M  output  1  direction to the counter; 0 = up, 1 = down.
REQ-012 CNT_CE  output  1  counter enable.
REQ-013 CNT_LD  output  1  counter synchronous load.
REQ-014 GNT  output  2  one-hot grant; registered.
REQ-015 DONE  output  2  one-cycle completion pulse per requester; registered.
REQ-016 BUSY  output  1  high in any state other than IDLE; registered.

Function
REQ-017 The FSM SHALL have four states: IDLE, LOAD, RUN, FIN.
REQ-018 IDLE: with any REQ bit high, the block SHALL select a winner by 2-way round-robin, latch its LDV and DIR, set GNT, and go to LOAD; otherwise it SHALL stay in IDLE.
REQ-019 Round-robin: the requester not granted last SHALL win when both request; a single requester SHALL win regardless of the pointer.
REQ-020 LOAD: for exactly one cycle, CNT_LD=1, CNT_CE=1, CNT_D=latched LDV, CNT_M=latched DIR; next state RUN.
REQ-021 RUN: CNT_CE SHALL be 1 only while CNT_Q != terminal (TERM_UP if up, TERM_DN if down); CNT_CE is combinational on CNT_Q, so the counter stops exactly at terminal.
REQ-022 RUN: when CNT_Q == terminal, the FSM SHALL go to FIN; a preload equal to terminal gives zero counting cycles.
REQ-023 FIN: DONE[winner] SHALL pulse high for exactly one cycle; GNT SHALL clear; the RR pointer SHALL update to the winner; next state IDLE.
REQ-024 Outside LOAD, CNT_LD SHALL be 0 and CNT_D SHALL hold the latched value; CNT_M SHALL hold latched DIR from LOAD through FIN.
REQ-025 Abort: if REQ[winner] falls in LOAD or RUN, CNT_CE SHALL be 0 that cycle, the FSM SHALL go to IDLE, GNT SHALL clear, no DONE SHALL pulse, and the pointer SHALL update to the winner.
REQ-026 A new grant SHALL NOT be issued in the cycle leaving FIN or abort; minimum one IDLE cycle between jobs.
REQ-027 Changes to LDVi/DIR after latching SHALL NOT affect the running job.
REQ-028 GNT SHALL be one-hot or zero at all times; DONE SHALL never have both bits set.

Reset
REQ-029 RST high SHALL force IDLE, GNT=0, DONE=0, BUSY=0, CNT_LD=0, CNT_CE=0, CNT_D=0, CNT_M=0, and the RR pointer to favour requester 0, immediately and without a clock.
REQ-030 Reset mid-job SHALL discard the job without DONE; the first grant after release SHALL follow REQ-018.

Structure
REQ-031 The state encoding and the default terminal constants SHALL be in the shared package cnt_seq_pkg.
REQ-032 Arbitration SHALL be one sub-module, rr_arb2 (REQ, pointer in -> one-hot grant out); the FSM and counter-drive logic SHALL be in cnt_seq_arb.

Verification
REQ-033 REQ=01, DIR0=0, LDV0=C -> GNT=01; one CNT_LD cycle with CNT_D=C; CNT_Q C,D,E,F with CE high for 3 cycles; CE low at F; DONE=01 for 1 cycle.
REQ-034 REQ=10, DIR1=1, LDV1=3 -> CNT_Q 3,2,1,0; DONE=10 once; CNT_M=1 throughout the job.
REQ-035 REQ=11 held constantly -> grants alternate 01,10,01,10; at least one IDLE cycle between jobs; after reset the first grant is 01.
REQ-036 LDV0=F, up -> LOAD, then RUN with CE=0, then DONE=01; zero counting cycles.
REQ-037 REQ0 dropped during RUN at CNT_Q=7 -> CE=0 that cycle, GNT=00 next cycle, no DONE; a pending REQ1 is granted next.
REQ-038 RST asserted during RUN -> all outputs 0 asynchronously; after release with REQ=10 -> GNT=10.

Source files
------------

// File: rtl/cnt_seq_pkg.sv
// Shared types and constants for the counter-sequencing arbiter.
// Holds the FSM state encoding and the default terminal counts.
package cnt_seq_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        RUN  = 2'd2,
        FIN  = 2'd3
    } seq_state_e;

    localparam logic [3:0] TERM_UP_DEF = 4'hF;
    localparam logic [3:0] TERM_DN_DEF = 4'h0;

    // Requester index to one-hot grant/done vector.
    function automatic logic [1:0] idx2oh(input logic idx);
        return idx ? 2'b10 : 2'b01;
    endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter: ptr names the requester favoured on a tie.
// A lone requester wins regardless of ptr; no request gives a zero grant.
module rr_arb2 (
    input  logic [1:0] req,
    input  logic       ptr,
    output logic [1:0] gnt
);

    always_comb begin
        gnt = req;
        if (req == 2'b11)
            gnt = ptr ? 2'b10 : 2'b01;
    end

endmodule

// File: rtl/cnt_seq_arb.sv
// Arbitrates two requesters for a shared loadable up/down counter and
// sequences each granted job through load, count-to-terminal and completion.
module cnt_seq_arb
    import cnt_seq_pkg::*;
#(
    parameter logic [3:0] TERM_UP = TERM_UP_DEF,
    parameter logic [3:0] TERM_DN = TERM_DN_DEF
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic [1:0] REQ,
    input  logic [1:0] DIR,
    input  logic [3:0] LDV0,
    input  logic [3:0] LDV1,
    input  logic [3:0] CNT_Q,
    output logic [3:0] CNT_D,
    output logic       CNT_M,
    output logic       CNT_CE,
    output logic       CNT_LD,
    output logic [1:0] GNT,
    output logic [1:0] DONE,
    output logic       BUSY
);

    seq_state_e state, nxt;
    logic [1:0] arb_gnt;
    logic       ptr;
    logic       win;
    logic       dir_q;
    logic [3:0] ldv_q;
    logic [3:0] term;
    logic       win_req;
    logic       at_term;
    logic       abort;

    rr_arb2 u_arb (
        .req (REQ),
        .ptr (ptr),
        .gnt (arb_gnt)
    );

    assign win_req = REQ[win];
    assign term    = dir_q ? TERM_DN : TERM_UP;
    assign at_term = (CNT_Q == term);
    // Winner withdrawing its request cancels the job before it can finish.
    assign abort   = ((state == LOAD) || (state == RUN)) && !win_req;

    assign CNT_D = ldv_q;
    assign CNT_M = dir_q;

    always_comb begin
        nxt    = state;
        CNT_CE = 1'b0;
        CNT_LD = 1'b0;
        case (state)
            IDLE: begin
                if (|REQ)
                    nxt = LOAD;
            end
            LOAD: begin
                CNT_LD = 1'b1;
                if (abort) begin
                    nxt = IDLE;
                end else begin
                    CNT_CE = 1'b1;
                    nxt    = RUN;
                end
            end
            RUN: begin
                // Enable is gated on CNT_Q directly so the counter parks on terminal.
                if (abort)
                    nxt = IDLE;
                else if (at_term)
                    nxt = FIN;
                else
                    CNT_CE = 1'b1;
            end
            FIN: begin
                nxt = IDLE;
            end
            default: nxt = IDLE;
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state <= IDLE;
            ptr   <= 1'b0;
            win   <= 1'b0;
            dir_q <= 1'b0;
            ldv_q <= 4'h0;
            GNT   <= 2'b00;
            DONE  <= 2'b00;
            BUSY  <= 1'b0;
        end else begin
            state <= nxt;
            BUSY  <= (nxt != IDLE);
            DONE  <= ((state == RUN) && (nxt == FIN)) ? idx2oh(win) : 2'b00;
            if ((state == IDLE) && (|REQ)) begin
                win   <= arb_gnt[1];
                ldv_q <= arb_gnt[1] ? LDV1 : LDV0;
                dir_q <= DIR[arb_gnt[1]];
                GNT   <= arb_gnt;
            end else if (nxt == IDLE) begin
                GNT <= 2'b00;
            end
            // Completed and aborted jobs both hand priority to the other requester.
            if ((state == FIN) || abort)
                ptr <= ~win;
        end
    end

    a_gnt_onehot0: assert property (@(posedge CLK) disable iff (RST) $onehot0(GNT));
    a_done_excl:   assert property (@(posedge CLK) disable iff (RST) DONE != 2'b11);
    a_ld_single:   assert property (@(posedge CLK) disable iff (RST) CNT_LD |=> !CNT_LD);

endmodule

// File: tb/tb_cnt_seq_arb.sv
// Directed bench for cnt_seq_arb with an external counter and a job-level
// reference model compared every cycle, plus hand-computed pinned values.
module tb_cnt_seq_arb;

    logic       CLK  = 1'b0;
    logic       RST  = 1'b0;
    logic [1:0] REQ  = 2'b00;
    logic [1:0] DIR  = 2'b00;
    logic [3:0] LDV0 = 4'h0;
    logic [3:0] LDV1 = 4'h0;
    logic [3:0] CNT_Q = 4'h0;
    logic [3:0] CNT_D;
    logic       CNT_M, CNT_CE, CNT_LD, BUSY;
    logic [1:0] GNT, DONE;

    int n_chk  = 0;
    int n_pass = 0;

    cnt_seq_arb dut (
        .CLK(CLK), .RST(RST), .REQ(REQ), .DIR(DIR), .LDV0(LDV0), .LDV1(LDV1),
        .CNT_Q(CNT_Q), .CNT_D(CNT_D), .CNT_M(CNT_M), .CNT_CE(CNT_CE),
        .CNT_LD(CNT_LD), .GNT(GNT), .DONE(DONE), .BUSY(BUSY)
    );

    always #5 CLK = ~CLK;

    // Shared loadable up/down counter the block is driving.
    always @(posedge CLK)
        if (CNT_CE)
            CNT_Q <= CNT_LD ? CNT_D : (CNT_M ? CNT_Q - 4'd1 : CNT_Q + 4'd1);

    // Reference model: one job at a time, phase 0 idle, 1 load, 2 count, 3 finish.
    localparam int P_IDLE = 0, P_LOAD = 1, P_RUN = 2, P_FIN = 3;
    int         m_phase = P_IDLE;
    logic       m_owner = 1'b0;
    logic       m_fav   = 1'b0;
    logic       m_dir   = 1'b0;
    logic [3:0] m_ldv   = 4'h0;
    logic [1:0] m_gnt   = 2'b00;
    logic [1:0] m_done  = 2'b00;

    function automatic logic pick(input logic [1:0] r, input logic fav);
        if (r == 2'b11) return fav;
        return r[1];
    endfunction

    function automatic logic [3:0] term_of(input logic d);
        return d ? 4'h0 : 4'hF;
    endfunction

    always @(posedge CLK or posedge RST) begin
        if (RST) begin
            m_phase <= P_IDLE; m_owner <= 1'b0; m_fav <= 1'b0; m_dir <= 1'b0;
            m_ldv <= 4'h0; m_gnt <= 2'b00; m_done <= 2'b00;
        end else begin
            m_done <= 2'b00;
            case (m_phase)
                P_IDLE: if (REQ != 2'b00) begin
                    m_owner <= pick(REQ, m_fav);
                    m_ldv   <= pick(REQ, m_fav) ? LDV1 : LDV0;
                    m_dir   <= DIR[pick(REQ, m_fav)];
                    m_gnt   <= pick(REQ, m_fav) ? 2'b10 : 2'b01;
                    m_phase <= P_LOAD;
                end
                P_LOAD, P_RUN: begin
                    if (!REQ[m_owner]) begin
                        m_phase <= P_IDLE; m_gnt <= 2'b00; m_fav <= !m_owner;
                    end else if (m_phase == P_LOAD) begin
                        m_phase <= P_RUN;
                    end else if (CNT_Q == term_of(m_dir)) begin
                        m_phase <= P_FIN;
                        m_done  <= m_owner ? 2'b10 : 2'b01;
                    end
                end
                default: begin
                    m_phase <= P_IDLE; m_gnt <= 2'b00; m_fav <= !m_owner;
                end
            endcase
        end
    end

    task automatic check(input string nm, input logic [3:0] act, input logic [3:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    endtask

    task automatic bound_fail(input string nm);
        n_chk++;
        $display("FAIL %s: got timeout expected completion at %0t", nm, $time);
    endtask

    task automatic compare_all();
        logic       own;
        logic       ece;
        own = REQ[m_owner];
        ece = ((m_phase == P_LOAD) && own) ||
              ((m_phase == P_RUN) && own && (CNT_Q != term_of(m_dir)));
        check("gnt",  4'(GNT),  4'(m_gnt));
        check("done", 4'(DONE), 4'(m_done));
        check("busy", 4'(BUSY), 4'(m_phase != P_IDLE));
        check("ld",   4'(CNT_LD), 4'(m_phase == P_LOAD));
        check("ce",   4'(CNT_CE), 4'(ece));
        check("d",    CNT_D, m_ldv);
        check("m",    4'(CNT_M), 4'(m_dir));
        check("gnt_onehot0", 4'($onehot0(GNT)), 4'd1);
        check("done_excl",   4'(DONE != 2'b11), 4'd1);
    endtask

    task automatic tick();
        @(negedge CLK);
        compare_all();
    endtask

    typedef struct {
        int         nld, nce, ndone;
        logic [1:0] g1, dv;
        logic       m_all;
        logic [3:0] d_ld;
        bit         ok;
    } job_t;

    // Runs cycles until the block has been busy and returns to idle.
    task automatic run_job(output job_t r);
        bit seen = 0;
        r.nld = 0; r.nce = 0; r.ndone = 0; r.g1 = 2'b00; r.dv = 2'b00;
        r.m_all = 1'b1; r.d_ld = 4'h0; r.ok = 0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (CNT_LD) begin r.nld++; r.d_ld = CNT_D; end
            if (CNT_CE && !CNT_LD) r.nce++;
            if (DONE != 2'b00) begin r.ndone++; r.dv = DONE; end
            if (GNT != 2'b00 && r.g1 == 2'b00) r.g1 = GNT;
            if (BUSY && !CNT_M) r.m_all = 1'b0;
            // Latched job must ignore later preload changes.
            if (i == 0) begin LDV0 = LDV0 ^ 4'h5; LDV1 = LDV1 ^ 4'h5; end
            if (BUSY) seen = 1;
            else if (seen) begin r.ok = 1; break; end
        end
        if (!r.ok) bound_fail("job_end");
    endtask

    initial begin
        job_t r;
        bit   found;
        logic [1:0] exp_alt [4] = '{2'b01, 2'b10, 2'b01, 2'b10};

        #1 RST = 1'b1;
        #2;
        check("rst_gnt", 4'(GNT), 4'h0);
        check("rst_done", 4'(DONE), 4'h0);
        check("rst_busy", 4'(BUSY), 4'h0);
        check("rst_ld", 4'(CNT_LD), 4'h0);
        check("rst_ce", 4'(CNT_CE), 4'h0);
        tick();
        RST = 1'b0;

        // Up job from C: three counting cycles, stops at F.
        LDV0 = 4'hC; DIR = 2'b00; REQ = 2'b01;
        run_job(r);
        check("a_gnt", 4'(r.g1), 4'h1);
        check("a_nld", 4'(r.nld), 4'd1);
        check("a_d", r.d_ld, 4'hC);
        check("a_nce", 4'(r.nce), 4'd3);
        check("a_ndone", 4'(r.ndone), 4'd1);
        check("a_dv", 4'(r.dv), 4'h1);
        REQ = 2'b00;
        tick();

        // Down job from 3 on requester 1.
        LDV1 = 4'h3; DIR = 2'b10; REQ = 2'b10;
        run_job(r);
        check("b_gnt", 4'(r.g1), 4'h2);
        check("b_d", r.d_ld, 4'h3);
        check("b_nce", 4'(r.nce), 4'd3);
        check("b_ndone", 4'(r.ndone), 4'd1);
        check("b_dv", 4'(r.dv), 4'h2);
        check("b_m_all", 4'(r.m_all), 4'h1);
        REQ = 2'b00;

        // Both requesting constantly after a reset: grants alternate from 0.
        #2 RST = 1'b1;
        tick();
        RST = 1'b0; LDV0 = 4'hE; LDV1 = 4'h1; DIR = 2'b10; REQ = 2'b11;
        for (int j = 0; j < 4; j++) begin
            run_job(r);
            check("c_alt_gnt", 4'(r.g1), 4'(exp_alt[j]));
            check("c_idle_gap", 4'(GNT), 4'h0);
        end
        REQ = 2'b00;
        tick();

        // Preload already at terminal: load then straight to done.
        LDV0 = 4'hF; DIR = 2'b00; REQ = 2'b01;
        run_job(r);
        check("d_gnt", 4'(r.g1), 4'h1);
        check("d_nld", 4'(r.nld), 4'd1);
        check("d_nce", 4'(r.nce), 4'd0);
        check("d_ndone", 4'(r.ndone), 4'd1);
        check("d_dv", 4'(r.dv), 4'h1);
        REQ = 2'b00;
        tick();

        // Requester 0 withdraws at CNT_Q=7 with requester 1 waiting.
        LDV0 = 4'h4; LDV1 = 4'h2; DIR = 2'b10; REQ = 2'b01;
        tick();
        REQ = 2'b11;
        found = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (CNT_Q == 4'h7 && BUSY) begin found = 1; break; end
        end
        if (!found) bound_fail("e_reach7");
        REQ = 2'b10;
        #1 check("e_abort_ce", 4'(CNT_CE), 4'h0);
        tick();
        check("e_gnt_clr", 4'(GNT), 4'h0);
        check("e_no_done", 4'(DONE), 4'h0);
        check("e_busy", 4'(BUSY), 4'h0);
        tick();
        check("e_next_gnt", 4'(GNT), 4'h2);
        run_job(r);
        check("e_ndone", 4'(r.ndone), 4'd1);
        check("e_dv", 4'(r.dv), 4'h2);
        REQ = 2'b00;
        tick();

        // Reset mid-count clears everything without a clock.
        LDV0 = 4'h8; DIR = 2'b01; REQ = 2'b01;
        tick(); tick(); tick();
        #2 RST = 1'b1;
        #1;
        check("f_gnt", 4'(GNT), 4'h0);
        check("f_done", 4'(DONE), 4'h0);
        check("f_busy", 4'(BUSY), 4'h0);
        check("f_ld", 4'(CNT_LD), 4'h0);
        check("f_ce", 4'(CNT_CE), 4'h0);
        check("f_d", CNT_D, 4'h0);
        check("f_m", 4'(CNT_M), 4'h0);
        REQ = 2'b10; DIR = 2'b00; LDV1 = 4'hD;
        tick();
        RST = 1'b0;
        tick();
        check("f_first_gnt", 4'(GNT), 4'h2);
        run_job(r);
        check("f_dv", 4'(r.dv), 4'h2);
        REQ = 2'b00;
        tick();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
